// File: rtl/spmv_pkg.sv
// Shared types and helpers for the SpMV row accumulator slice.
package spmv_pkg;

    localparam int SPMV_DATA_WIDTH = 32;
    localparam int SPMV_LANE_WIDTH = 2 * SPMV_DATA_WIDTH;
    localparam int SPMV_ACC_WIDTH  = 80;

    typedef logic signed [SPMV_ACC_WIDTH-1:0] acc_t;

    typedef enum logic {
        ACC_EMPTY   = 1'b0,
        ACC_PARTIAL = 1'b1
    } acc_state_e;

    function automatic acc_t sext_lane(input logic [SPMV_LANE_WIDTH-1:0] lane);
        return acc_t'($signed(lane));
    endfunction

endpackage

// File: rtl/spmv_row_accumulator_lane_adder_tree.sv
// Combinational masked adder tree: sign-extends each enabled lane and sums all lanes.
module lane_adder_tree #(
    parameter int PARALLELISM = 4,
    parameter int IN_WIDTH    = 64,
    parameter int OUT_WIDTH   = 80
) (
    input  logic [PARALLELISM-1:0][IN_WIDTH-1:0] lanes_i,
    input  logic [PARALLELISM-1:0]               mask_i,
    output logic signed [OUT_WIDTH-1:0]          sum_o
);

    if (PARALLELISM == 1) begin : g_leaf
        assign sum_o = mask_i[0] ? OUT_WIDTH'($signed(lanes_i[0])) : '0;
    end else begin : g_split
        // Uneven splits put the extra lane in the upper half so any lane count works.
        localparam int LO = PARALLELISM / 2;
        localparam int HI = PARALLELISM - LO;

        logic signed [OUT_WIDTH-1:0] sum_lo;
        logic signed [OUT_WIDTH-1:0] sum_hi;

        lane_adder_tree #(
            .PARALLELISM(LO),
            .IN_WIDTH   (IN_WIDTH),
            .OUT_WIDTH  (OUT_WIDTH)
        ) u_lo (
            .lanes_i(lanes_i[LO-1:0]),
            .mask_i (mask_i[LO-1:0]),
            .sum_o  (sum_lo)
        );

        lane_adder_tree #(
            .PARALLELISM(HI),
            .IN_WIDTH   (IN_WIDTH),
            .OUT_WIDTH  (OUT_WIDTH)
        ) u_hi (
            .lanes_i(lanes_i[PARALLELISM-1:LO]),
            .mask_i (mask_i[PARALLELISM-1:LO]),
            .sum_o  (sum_hi)
        );

        assign sum_o = sum_lo + sum_hi;
    end

endmodule

// File: rtl/spmv_row_accumulator.sv
// Accumulates lane-reduced product beats into per-row sums and emits one tagged
// result per row through a single-entry valid/ready output register.
module spmv_row_accumulator
    import spmv_pkg::*;
#(
    parameter int DATA_WIDTH  = SPMV_DATA_WIDTH,
    parameter int PARALLELISM = 4,
    parameter int ACC_WIDTH   = SPMV_ACC_WIDTH,
    parameter int ROW_WIDTH   = 16,
    parameter int BEAT_WIDTH  = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [PARALLELISM-1:0][2*DATA_WIDTH-1:0] prod,
    input  logic [PARALLELISM-1:0]                   lane_mask,
    input  logic                                     in_last,
    output logic signed [ACC_WIDTH-1:0]              out_sum,
    output logic [ROW_WIDTH-1:0]                     out_row,
    output logic [BEAT_WIDTH-1:0]                    out_beats,
    output logic                                     out_valid,
    input  logic                                     out_ready
);

    acc_state_e                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [BEAT_WIDTH-1:0]       beats_q, beats_d;
    logic [ROW_WIDTH-1:0]        row_cnt_q, row_cnt_d;
    logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
    logic [ROW_WIDTH-1:0]        row_q, row_d;
    logic [BEAT_WIDTH-1:0]       out_beats_q, out_beats_d;
    logic                        valid_q, valid_d;

    logic signed [ACC_WIDTH-1:0] beat_sum;
    logic signed [ACC_WIDTH-1:0] acc_plus;
    logic                        accept;

    lane_adder_tree #(
        .PARALLELISM(PARALLELISM),
        .IN_WIDTH   (2 * DATA_WIDTH),
        .OUT_WIDTH  (ACC_WIDTH)
    ) u_tree (
        .lanes_i(prod),
        .mask_i (lane_mask),
        .sum_o  (beat_sum)
    );

    // A draining output slot frees the register in the same cycle, keeping single-beat rows at full rate.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign acc_plus = acc_q + beat_sum;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        row_cnt_d   = row_cnt_q;
        sum_d       = sum_q;
        row_d       = row_q;
        out_beats_d = out_beats_q;
        valid_d     = valid_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (in_last) begin
                sum_d       = acc_plus;
                out_beats_d = beats_q + BEAT_WIDTH'(1);
                row_d       = row_cnt_q;
                valid_d     = 1'b1;
                row_cnt_d   = row_cnt_q + ROW_WIDTH'(1);
                acc_d       = '0;
                beats_d     = '0;
                state_d     = ACC_EMPTY;
            end else begin
                acc_d   = acc_plus;
                beats_d = beats_q + BEAT_WIDTH'(1);
                state_d = ACC_PARTIAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC_EMPTY;
            acc_q       <= '0;
            beats_q     <= '0;
            row_cnt_q   <= '0;
            sum_q       <= '0;
            row_q       <= '0;
            out_beats_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            row_cnt_q   <= row_cnt_d;
            sum_q       <= sum_d;
            row_q       <= row_d;
            out_beats_q <= out_beats_d;
            valid_q     <= valid_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_row   = row_q;
    assign out_beats = out_beats_q;
    assign out_valid = valid_q;

endmodule
